// File: rtl/seq_divider_16x8.sv
// 16-bit by 8-bit unsigned restoring divider, one quotient bit per clock.
// A zero divisor skips iteration and returns quotient 0xFFFF with the dividend's low byte as remainder.
module seq_divider_16x8 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] dvd_sr;
  logic [15:0] quo_sr;
  logic [7:0]  dsr;
  logic [7:0]  rem;
  logic [4:0]  cnt;
  logic [8:0]  part;
  logic        ge;
  logic [7:0]  diff;

  // The stored remainder is always below the divisor, so only the shifted
  // 9-bit partial value needs the extra bit for the compare.
  always_comb begin
    part = {rem, dvd_sr[15]};
    ge   = (part >= {1'b0, dsr});
    diff = part[7:0] - dsr;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? FINISH : CALC;
      CALC:    if (cnt == 5'd1) state_nxt = FINISH;
      FINISH:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done is registered out of DONE, so busy also covers that trailing cycle.
  always_comb begin
    busy = (state != IDLE) | done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_sr    <= '0;
      quo_sr    <= '0;
      dsr       <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            dvd_sr <= dividend;
            dsr    <= divisor;
            quo_sr <= '0;
            rem    <= '0;
            cnt    <= 5'd16;
          end
        end
        CALC: begin
          dvd_sr <= {dvd_sr[14:0], 1'b0};
          quo_sr <= {quo_sr[14:0], ge};
          rem    <= ge ? diff : part[7:0];
          cnt    <= cnt - 5'd1;
        end
        FINISH: begin
          if (dsr == '0) begin
            quotient  <= '1;
            remainder <= dvd_sr[7:0];
            div_zero  <= 1'b1;
          end else begin
            quotient  <= quo_sr;
            remainder <= rem;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Scoreboard bench for seq_divider_16x8: the driver queues expected results,
// a negedge monitor checks them (value and delivery edge) on every done pulse.
module tb_seq_divider_16x8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  seq_divider_16x8 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          at;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_quotient"},  32'(quotient),  32'(mon_e.q));
        chk({mon_e.nm, "_remainder"}, 32'(remainder), 32'(mon_e.r));
        chk({mon_e.nm, "_div_zero"},  32'(div_zero),  32'(mon_e.dz));
        chk({mon_e.nm, "_done_edge"}, 32'(cyc),       32'(mon_e.at));
      end
    end
  end

  task automatic push_exp(input logic [15:0] q, input logic [7:0] r, input logic dz,
                          input int at, input string nm);
    exp_t ex;
    ex.q = q; ex.r = r; ex.dz = dz; ex.at = at; ex.nm = nm;
    sb.push_back(ex);
  endtask

  // Called at a negedge with the DUT idle; returns at the following negedge.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dsr,
                        input logic [15:0] q, input logic [7:0] r, input logic dz,
                        input string nm, input bit push, output int acc);
    dividend = dvd;
    divisor  = dsr;
    start    = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) push_exp(q, r, dz, acc + ((dsr == 8'd0) ? 2 : 18), nm);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_cyc(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [15:0] rd;
    logic [7:0]  rs;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_quotient",  32'(quotient),  32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_div_zero",  32'(div_zero),  32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1000 / 7 = 142 r 6, with busy spanning edges 0..19
    run_op(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, "basic", 1'b1, acc);
    chk("basic_busy_e0", 32'(busy), 32'd1);
    wait_cyc(acc + 18);
    chk("basic_busy_e18", 32'(busy), 32'd1);
    wait_cyc(acc + 19);
    chk("basic_busy_e19", 32'(busy), 32'd0);

    run_op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, "max", 1'b1, acc);
    wait_idle();
    run_op(16'h0003, 8'h0A, 16'h0000, 8'h03, 1'b0, "small", 1'b1, acc);
    wait_cyc(acc + 10);
    chk("hold_quotient",  32'(quotient),  32'h0101);
    chk("hold_remainder", 32'(remainder), 32'h00);
    wait_idle();

    // 0x1234 / 0 -> 0xFFFF r 0x34, then a valid op clears div_zero only in FINISH
    run_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, "divzero", 1'b1, acc);
    wait_idle();
    run_op(16'h0064, 8'h09, 16'h000B, 8'h01, 1'b0, "after_dz", 1'b1, acc);
    wait_cyc(acc + 10);
    chk("dz_held_in_calc", 32'(div_zero), 32'd1);
    wait_idle();

    // A start pulse at edge 5 with new operands must be ignored
    run_op(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, "start_busy", 1'b1, acc);
    wait_cyc(acc + 4);
    dividend = 16'hFFFF;
    divisor  = 8'h01;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    wait_idle();

    // start held high: second op accepted 19 edges after the first
    dividend = 16'hFFFF;
    divisor  = 8'hFF;
    start    = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    push_exp(16'h0101, 8'h00, 1'b0, acc + 18, "b2b_first");
    push_exp(16'h000B, 8'h01, 1'b0, acc + 37, "b2b_second");
    dividend = 16'h0064;
    divisor  = 8'h09;
    repeat (19) @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy_e19", 32'(busy), 32'd1);
    @(negedge clk);
    wait_idle();

    // Reset at edge 9 of an op, with non-zero outputs from a prior div-by-zero
    run_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, "pre_rst", 1'b1, acc);
    wait_idle();
    run_op(16'h03E8, 8'h07, 16'h0000, 8'h00, 1'b0, "aborted", 1'b0, acc);
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_quotient",  32'(quotient),  32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_done",      32'(done),      32'd0);
    chk("midrst_div_zero",  32'(div_zero),  32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(16'h0064, 8'h09, 16'h000B, 8'h01, 1'b0, "post_rst", 1'b1, acc);
    wait_idle();

    run_op(16'h0000, 8'h01, 16'h0000, 8'h00, 1'b0, "zero_by_one", 1'b1, acc);
    wait_idle();
    run_op(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, "max_by_one", 1'b1, acc);
    wait_idle();
    run_op(16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0, "ff_by_ff", 1'b1, acc);
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      rd = 16'($urandom_range(0, 65535));
      rs = 8'($urandom_range(1, 255));
      run_op(rd, rs, rd / 16'(rs), 8'(rd % 16'(rs)), 1'b0, "rand", 1'b1, acc);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
